// File: rtl/cpu_pkg.sv
// cpu_pkg: types and defaults shared by the pipelined CPU register file.
//   DATA_W / ADDR_W : default register width and register address width
//   reg_addr_t      : register index type
//   word_t          : register data type
//   ZERO_ADDR       : index of the hardwired zero register
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_addr_t ZERO_ADDR = '0;
endpackage

// File: rtl/pipe_regfile_if.sv
// pipe_regfile_if: bundles the read ports, writeback, issue and scoreboard
// signals of the register file.
//   master : pipeline side (drives addresses, writeback, issue, flush)
//   slave  : register file side (drives read data, pending flags, count, orphan)
//
// Signalling: wr_en and iss_en are single-cycle qualifiers with no back-pressure.
// A transaction is taken on every rising clk edge where its enable is high; the
// register file is always ready, so there is no ready signal.
interface pipe_regfile_if #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREAD  = 2
);
    logic [NREAD*ADDR_W-1:0] rd_addr;
    logic [NREAD*DATA_W-1:0] rd_data;
    logic [NREAD-1:0]        rd_pending;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    iss_en;
    logic [ADDR_W-1:0]       iss_addr;
    logic                    flush;
    logic [ADDR_W:0]         pend_count;
    logic                    wr_orphan;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_pending, pend_count, wr_orphan
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_pending, pend_count, wr_orphan
    );
endinterface

// File: rtl/pipe_regfile_rf_read_port.sv
// rf_read_port: one combinational read port of the register file.
//   addr      : register being read
//   wr_*      : writeback of this cycle (for bypass and pending clear)
//   iss_*     : issue of this cycle (a same-address issue keeps the source pending)
//   mem_word  : stored value of register addr
//   pend_bit  : stored pending bit of register addr
//   data      : value seen by decode
//   pending   : source still has an outstanding producer
module rf_read_port
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [DATA_W-1:0] mem_word,
    input  logic              pend_bit,
    output logic [DATA_W-1:0] data,
    output logic              pending
);
    logic is_zero;
    logic wr_hit;
    logic iss_hit;

    always_comb begin
        is_zero = (ZERO_REG != 0) && (addr == '0);
        wr_hit  = wr_en && (wr_addr == addr);
        iss_hit = iss_en && (iss_addr == addr);

        if (is_zero) begin
            data = '0;
        end else if (wr_hit) begin
            data = wr_data;
        end else begin
            data = mem_word;
        end

        // A writeback retires the producer unless a newer producer issues to
        // the same register in this very cycle.
        pending = pend_bit && !(wr_hit && !iss_hit) && !is_zero;
    end
endmodule

// File: rtl/pipe_regfile.sv
// pipe_regfile: parametrised register file with per-register pending
// scoreboard, same-cycle write bypass and optional hardwired zero register.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : pipe_regfile_if slave (read ports, writeback, issue, flush,
//         pend_count, wr_orphan)
module pipe_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           rst,
    pipe_regfile_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [ADDR_W:0]   pend_count_q, pend_count_d;
    logic              wr_orphan_q, wr_orphan_d;

    logic [NREAD*DATA_W-1:0] rd_data_w;
    logic [NREAD-1:0]        rd_pending_w;

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic wr_is_zero;
    logic iss_is_zero;

    always_comb begin
        wr_is_zero  = (ZERO_REG != 0) && (bus.wr_addr == '0);
        iss_is_zero = (ZERO_REG != 0) && (bus.iss_addr == '0);

        mem_d = mem_q;
        if (bus.wr_en && !wr_is_zero) begin
            mem_d[bus.wr_addr] = bus.wr_data;
        end

        // Clear first, then set: an issue to the register being written
        // leaves it pending because the new producer is younger.
        pend_d = pend_q;
        if (bus.flush) begin
            pend_d = '0;
        end else begin
            if (bus.wr_en && !wr_is_zero) begin
                pend_d[bus.wr_addr] = 1'b0;
            end
            if (bus.iss_en && !iss_is_zero) begin
                pend_d[bus.iss_addr] = 1'b1;
            end
        end

        pend_count_d = popcount(pend_d);

        wr_orphan_d = wr_orphan_q
                    | (bus.wr_en && !wr_is_zero && !pend_q[bus.wr_addr]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q        <= '{default: '0};
            pend_q       <= '0;
            pend_count_q <= '0;
            wr_orphan_q  <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            pend_q       <= pend_d;
            pend_count_q <= pend_count_d;
            wr_orphan_q  <= wr_orphan_d;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = bus.rd_addr[i*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .addr     (a),
            .wr_en    (bus.wr_en),
            .wr_addr  (bus.wr_addr),
            .wr_data  (bus.wr_data),
            .iss_en   (bus.iss_en),
            .iss_addr (bus.iss_addr),
            .mem_word (mem_q[a]),
            .pend_bit (pend_q[a]),
            .data     (rd_data_w[i*DATA_W +: DATA_W]),
            .pending  (rd_pending_w[i])
        );
    end

    assign bus.rd_data    = rd_data_w;
    assign bus.rd_pending = rd_pending_w;
    assign bus.pend_count = pend_count_q;
    assign bus.wr_orphan  = wr_orphan_q;
endmodule

// File: tb/tb_pipe_regfile.sv
module tb_pipe_regfile;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) bus ();

    pipe_regfile #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NREAD    (NR),
        .ZERO_REG (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] rdd(input int i);
        return bus.rd_data[i*DW +: DW];
    endfunction

    task automatic idle();
        bus.wr_en    = 1'b0;
        bus.iss_en   = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        bus.rd_addr = {a3, a2, a1, a0};
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    task automatic iss(input logic [AW-1:0] a);
        bus.iss_en   = 1'b1;
        bus.iss_addr = a;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.iss_addr = '0;
        idle();
        set_rd(1, 2, 3, 4);

        // Reset held while random traffic is applied.
        repeat (4) begin
            @(negedge clk);
            wr(AW'($urandom_range(1, 31)), $urandom);
            iss(AW'($urandom_range(0, 31)));
        end
        @(negedge clk);
        idle();
        #2;
        for (int i = 0; i < NR; i++) begin
            push(32'd0); chk($sformatf("reset_rd_data%0d", i), rdd(i));
        end
        push(32'd0); chk("reset_rd_pending", {28'd0, bus.rd_pending});
        push(32'd0); chk("reset_pend_count", {26'd0, bus.pend_count});
        push(32'd0); chk("reset_wr_orphan", {31'd0, bus.wr_orphan});
        rst = 1'b1;

        @(negedge clk);
        set_rd(5, 0, 0, 0);
        #2;
        push(32'd0); chk("post_reset_r5", rdd(0));

        // Issue r5, then write it back with bypass.
        @(negedge clk);
        iss(5);
        @(negedge clk);
        idle();
        #2;
        push(32'd1); chk("r5_pending", {31'd0, bus.rd_pending[0]});
        push(32'd1); chk("r5_pend_count", {26'd0, bus.pend_count});
        @(negedge clk);
        wr(5, 32'h0000_000C);
        #2;
        push(32'd12); chk("r5_bypass", rdd(0));
        push(32'd0);  chk("r5_pending_cleared", {31'd0, bus.rd_pending[0]});
        @(negedge clk);
        idle();
        #2;
        push(32'd0);  chk("r5_pend_count_after_wb", {26'd0, bus.pend_count});
        push(32'd12); chk("r5_stored", rdd(0));

        // Zero register.
        @(negedge clk);
        set_rd(0, 0, 0, 0);
        iss(0);
        wr(0, 32'hFFFF_FFFF);
        #2;
        push(32'd0); chk("r0_no_bypass", rdd(0));
        push(32'd0); chk("r0_not_pending_same", {31'd0, bus.rd_pending[0]});
        @(negedge clk);
        idle();
        #2;
        push(32'd0); chk("r0_reads_zero", rdd(0));
        push(32'd0); chk("r0_not_pending", {31'd0, bus.rd_pending[0]});
        push(32'd0); chk("r0_pend_count", {26'd0, bus.pend_count});
        push(32'd0); chk("r0_no_orphan", {31'd0, bus.wr_orphan});

        // Same-address issue and write.
        @(negedge clk);
        iss(7);
        @(negedge clk);
        set_rd(7, 7, 7, 7);
        iss(7);
        wr(7, 32'd21);
        #2;
        push(32'd21); chk("r7_collide_bypass", rdd(0));
        push(32'd1);  chk("r7_collide_pending_same", {31'd0, bus.rd_pending[0]});
        @(negedge clk);
        idle();
        #2;
        push(32'd21); chk("r7_collide_data", rdd(0));
        push(32'd1);  chk("r7_collide_pending", {31'd0, bus.rd_pending[0]});
        push(32'd1);  chk("r7_collide_count", {26'd0, bus.pend_count});
        @(negedge clk);
        wr(7, 32'd22);
        @(negedge clk);
        idle();
        #2;
        push(32'd0); chk("r7_retired_count", {26'd0, bus.pend_count});

        // Fill the scoreboard, re-issue, then flush with a concurrent issue.
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            iss(AW'(a));
        end
        @(negedge clk);
        idle();
        set_rd(1, 3, 7, 31);
        #2;
        push(32'd31);  chk("full_pend_count", {26'd0, bus.pend_count});
        push(32'h0000_000F); chk("full_rd_pending", {28'd0, bus.rd_pending});
        @(negedge clk);
        iss(5);
        @(negedge clk);
        idle();
        #2;
        push(32'd31);  chk("reissue_pend_count", {26'd0, bus.pend_count});
        @(negedge clk);
        bus.flush = 1'b1;
        iss(3);
        @(negedge clk);
        idle();
        #2;
        push(32'd0); chk("flush_pend_count", {26'd0, bus.pend_count});
        push(32'd0); chk("flush_rd_pending", {28'd0, bus.rd_pending});
        push(32'd0); chk("pre_orphan", {31'd0, bus.wr_orphan});

        // Orphan write, persistence across flush, multi-port read.
        @(negedge clk);
        wr(9, 32'd3);
        @(negedge clk);
        idle();
        #2;
        push(32'd1); chk("orphan_set", {31'd0, bus.wr_orphan});
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        idle();
        set_rd(9, 9, 9, 9);
        #2;
        push(32'd1); chk("orphan_after_flush", {31'd0, bus.wr_orphan});
        for (int i = 0; i < NR; i++) begin
            push(32'd3); chk($sformatf("r9_port%0d", i), rdd(i));
        end

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
        end
        checks++;

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_regfile.md
# pipe_regfile

Parametrised register file with scoreboard for the pipelined CPU. It generalises the single-cycle register file to a configurable data width, depth and read-port count. It adds same-cycle write-to-read bypass, an optional hardwired zero register, and per-register pending (in-flight producer) tracking. Decode uses the pending bits for hazard stalls; writeback clears them.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W
- NREAD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, 1: register 0 reads 0, is never written and is never pending
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- rd_addr  in  NREAD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_pending  out  NREAD  port i source has an outstanding producer
- wr_en  in  1  writeback valid
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  DATA_W  writeback data
- iss_en  in  1  instruction issued with a destination
- iss_addr  in  ADDR_W  issued destination; marks it pending
- flush  in  1  synchronous clear of all pending bits (mispredict)
- pend_count  out  ADDR_W+1  number of pending registers, registered
- wr_orphan  out  1  sticky: a write hit a non-pending register

## Operation
- Storage: DEPTH x DATA_W array plus a DEPTH-bit pending vector.
- Read, per port, combinational:
  - If ZERO_REG and addr==0, rd_data = 0.
  - Else if wr_en and wr_addr==addr, rd_data = wr_data (bypass).
  - Else rd_data = array[addr].
- rd_pending, per port, combinational: pending[addr] and not (wr_en and wr_addr==addr and not iss_en-to-same-addr). It is always 0 for addr 0 when ZERO_REG=1.
- Write at clock edge: if wr_en and not (ZERO_REG and wr_addr==0), array[wr_addr] <= wr_data.
- Pending update at clock edge, in priority order:
  - flush clears all bits. An iss_en in the same cycle is then ignored.
  - iss_en sets pending[iss_addr].
  - wr_en clears pending[wr_addr].
  - iss_en and wr_en to the same address in one cycle: the bit ends set, because the newer producer wins. The data is still written.
- Issue to an already-pending register: bit stays set and the count is unchanged.
- Address 0 with ZERO_REG=1: iss and wr are ignored for the pending vector and for wr_orphan.
- pend_count is the population count of the next pending vector, registered. It equals the popcount of pending after every edge and never exceeds DEPTH.
- wr_orphan sets when wr_en targets a non-zero register whose pending bit is 0 before the edge. It clears only on reset. Flush does not clear it.

## Timing
- Read path has zero latency: combinational from rd_addr, wr_*, and state.
- Write and pending updates are visible on reads one cycle later. Bypass covers the same cycle.
- Reset (rst=0), asynchronous:
  - all registers go to 0 and all pending bits to 0;
  - pend_count goes to 0 and wr_orphan to 0;
  - rd_data shows 0 and rd_pending shows 0 unless a bypass is active.
- Reset mid-operation discards in-flight state immediately. No write completes on the edge where rst is low.
- Reset deassertion is not internally synchronised; the system provides a clean release.

## Structure
- Shared package cpu_pkg:
  - DATA_W and ADDR_W defaults;
  - typedef reg_addr_t (logic [ADDR_W-1:0]);
  - typedef word_t (logic [DATA_W-1:0]);
  - localparam ZERO_ADDR = '0.
- One sub-module, rf_read_port: the single-port bypass/zero/pending mux, instantiated NREAD times in a generate loop.
- The popcount is a function in the top module.

## Test plan
- Reset: hold rst=0 for 45 ns with random writes applied -> all reads 0, pend_count=0, wr_orphan=0; after release, read r5 -> 0.
- Issue, then write: iss r5, next cycle rd_addr0=5 -> rd_pending[0]=1, pend_count=1. Then wr r5=32'h0000_000C in the same cycle as reading r5 -> rd_data0=12 via bypass, rd_pending[0]=0. Next cycle: pend_count=0.
- Zero register: iss r0 and wr r0=32'hFFFF_FFFF -> r0 reads 0, never pending, pend_count unchanged, wr_orphan=0.
- Same-address collision: r7 pending; iss r7 and wr r7=21 in the same cycle -> r7 reads 21 next cycle, rd_pending=1, pend_count unchanged.
- Flush and full: issue r1..r31 -> pend_count=31. Then flush with iss r3 in the same cycle -> pend_count=0 and no register pending.
- Orphan write and multi-port: wr r9=3 with r9 not pending -> wr_orphan=1, stays 1 after flush. With NREAD=4, read r9 on all ports -> all return 3.
